seg_mux_display: RTL and testbench
==================================

SEG_MUX_DISPLAY -- requirements
Module: seg_mux_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed seven-segment digits (legal range 1..8).
REQ-002 The block SHALL have parameter DIV_BITS, default 16, meaning the refresh prescaler width (digit dwell = 2^DIV_BITS cycles).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have the following data ports:
- values  input  4*DIGITS  hex nibble per digit; digit i is values[4i+3:4i]; digit 0 is rightmost.
- dp  input  DIGITS  decimal point enable per digit.
- blank  input  DIGITS  force digit i dark.
- update  input  1  capture values/dp/blank into the shadow register this cycle.
- io_sel  output  DIGITS  digit select, active-low.
- io_seg  output  8  segments, active-low; bit 0..6 = a..g, bit 7 = dp.
- frame_done  output  1  one-cycle pulse at digit-index wrap.

Function
REQ-005 The prescaler SHALL count 0..2^DIV_BITS-1 and wrap; its terminal count is "tick".
REQ-006 On tick, the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-007 frame_done SHALL be 1 for exactly the cycle after the tick that wraps the index to 0.
REQ-008 update=1 SHALL copy values/dp/blank into shadow and set pending; a later update before frame wrap SHALL overwrite the shadow.
REQ-009 On the wrapping tick, if pending=1, the shadow SHALL be copied into the active register and pending cleared.
REQ-010 If update=1 coincides with the wrapping tick, the inputs SHALL go directly to the active register and pending SHALL be 0.
REQ-011 The display SHALL never show a mix of old and new frame data within one frame.
REQ-012 io_sel and io_seg SHALL be registered, with one cycle of latency from index/active-register change.
REQ-013 In the first cycle after each index change, io_sel SHALL be all ones (anti-ghosting guard); in the remaining cycles, only bit idx SHALL be 0.
REQ-014 io_seg[6:0] SHALL be the inverted hex glyph of the active nibble (0-9, A, b, C, d, E, F); io_seg[7] SHALL be ~dp[idx].
REQ-015 A digit with blank=1 SHALL drive io_seg = 8'hFF, including dp.
REQ-016 With DIGITS=1, the index SHALL stay 0 and frame_done SHALL pulse on every tick.

Reset
REQ-017 On rst=1 at a clk edge, the prescaler, idx, pending, shadow and active registers SHALL be cleared to 0.
REQ-018 On rst=1 at a clk edge, io_sel SHALL be all ones, io_seg SHALL be 8'hFF, and frame_done SHALL be 0.
REQ-019 Reset asserted mid-frame SHALL take effect on the same edge and discard any pending update.

Configuration
REQ-020 With macro SEG_LZ_SUPPRESS_EN defined, digit i>0 SHALL be blanked (segments a-g off) when it and every more-significant digit are 0.
REQ-021 Under SEG_LZ_SUPPRESS_EN, dp SHALL still be shown for a suppressed digit, and digit 0 SHALL never be suppressed.
REQ-022 Without SEG_LZ_SUPPRESS_EN, zeros SHALL display as "0" and no suppression logic SHALL be synthesised.

Structure
REQ-023 The shared package seg_pkg SHALL hold the 16 glyph constants (active-high a..g), SEG_OFF = 8'hFF, and the segment bit-index constants.
REQ-024 The combinational nibble-to-glyph decode SHALL be sub-module seg_hex_decode, instantiated once on the selected nibble.

Verification (DIGITS=4, DIV_BITS=2)
REQ-025 Reset release, then update with values=16'h12AF, dp=4'b0100, blank=0 -> after the first frame wrap, digit 0 shows io_seg=~F glyph and digit 2 shows io_seg[7]=0; io_sel cycles 1110, 1101, 1011, 0111, each preceded by a 1111 guard cycle.
REQ-026 Update with 16'h0000 mid-frame, then 16'h9999 before the wrap -> the active register becomes 16'h9999 at the wrap, and 16'h0000 is never displayed.
REQ-027 update=1 exactly on the wrapping tick with 16'h5555 -> the next frame shows 5 on all digits, and pending reads 0.
REQ-028 blank=4'b1000 with dp[3]=1 -> io_seg=8'hFF while io_sel=0111.
REQ-029 SEG_LZ_SUPPRESS_EN defined, values=16'h0070, dp=4'b1000 -> digit 3 shows only dp (io_seg=8'h7F), digit 2 is dark, digits 1 and 0 show 7 and 0.
REQ-030 rst pulsed while idx=2 -> on the next edge io_sel=4'hF and io_seg=8'hFF; after release, scanning restarts at digit 0 with 0 displayed.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display slice.
//   - Segment bit positions inside the 8-bit segment bus (a..g, dp).
//   - SEG_OFF: all segments dark on an active-low bus.
//   - Active-high a..g glyphs for hex digits 0-9, A, b, C, d, E, F.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Glyphs are active-high, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble-to-glyph decoder.
//   nibble : input  [3:0]  hex value to show
//   glyph  : output [6:0]  active-high segments, bit 0 = a ... bit 6 = g
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_0;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/seg_mux_display.sv
// seg_mux_display: time-multiplexed driver for DIGITS seven-segment digits.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   values      : one hex nibble per digit, digit 0 rightmost (values[3:0])
//   dp, blank   : per-digit decimal point enable / force-dark
//   update      : one-cycle strobe; captures values/dp/blank into the shadow
//                 register. There is no ready: every strobe is accepted, and
//                 a newer strobe before the frame wrap replaces the older one.
//   io_sel      : registered digit select, active-low
//   io_seg      : registered segments, active-low, bit 0..6 = a..g, bit 7 = dp
//   frame_done  : one-cycle pulse in the cycle after the index wraps to 0
//
// Parameters: DIGITS (1..8), DIV_BITS (>= 1, dwell = 2^DIV_BITS cycles).
//
// Build option: define SEG_LZ_SUPPRESS_EN to blank leading-zero digits
// (segments a-g off, dp still shown, digit 0 never blanked).
module seg_mux_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   values,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  update,
    output logic [DIGITS-1:0]     io_sel,
    output logic [7:0]            io_seg,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIV_BITS-1:0] CNT_MAX  = '1;

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tick, wrap;

    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic                pending_q, pending_d;

    logic [4*DIGITS-1:0] act_val_q, act_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;

    logic [DIGITS-1:0]   io_sel_q, io_sel_d;
    logic [7:0]          io_seg_q, io_seg_d;
    logic                frame_done_q, frame_done_d;

    logic [3:0]          sel_nib;
    logic                sel_dp, sel_blank, sel_lz;
    logic [6:0]          glyph;

    // Prescaler and digit index.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        wrap  = tick && (idx_q == LAST_IDX);
        cnt_d = cnt_q + DIV_BITS'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        frame_done_d = wrap;
    end

    // Shadow / active frame buffering. The active register only changes on
    // the wrapping tick, so a frame is always drawn from one data set.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        act_val_d      = act_val_q;
        act_dp_d       = act_dp_q;
        act_blank_d    = act_blank_q;
        if (wrap && update) begin
            // Fresh inputs win over anything still waiting in the shadow.
            act_val_d   = values;
            act_dp_d    = dp;
            act_blank_d = blank;
            pending_d   = 1'b0;
        end else if (wrap && pending_q) begin
            act_val_d   = shadow_val_q;
            act_dp_d    = shadow_dp_q;
            act_blank_d = shadow_blank_q;
            pending_d   = 1'b0;
        end else if (update) begin
            shadow_val_d   = values;
            shadow_dp_d    = dp;
            shadow_blank_d = blank;
            pending_d      = 1'b1;
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] lz_mask;

    // lz_mask[i] is set when digit i and every more-significant digit are 0.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (act_val_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz_mask[i] = run_zero;
            end
        end
    end
`endif

    // Select the current digit's data from the active register.
    always_comb begin
        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        sel_lz    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib   = act_val_q[4*i +: 4];
                sel_dp    = act_dp_q[i];
                sel_blank = act_blank_q[i];
`ifdef SEG_LZ_SUPPRESS_EN
                sel_lz    = lz_mask[i];
`endif
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (sel_nib),
        .glyph  (glyph)
    );

    // Output register inputs. cnt_q == 0 marks the first cycle after an
    // index change; all digits are deselected then to avoid ghosting.
    always_comb begin
        io_sel_d = '1;
        if (cnt_q != '0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    io_sel_d[i] = 1'b0;
                end
            end
        end

        io_seg_d = SEG_OFF;
        if (!sel_blank) begin
            io_seg_d[SEG_DP] = ~sel_dp;
            if (!sel_lz) begin
                io_seg_d[SEG_G:SEG_A] = ~glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            act_val_q      <= '0;
            act_dp_q       <= '0;
            act_blank_q    <= '0;
            io_sel_q       <= '1;
            io_seg_q       <= SEG_OFF;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            act_val_q      <= act_val_d;
            act_dp_q       <= act_dp_d;
            act_blank_q    <= act_blank_d;
            io_sel_q       <= io_sel_d;
            io_seg_q       <= io_seg_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign io_sel     = io_sel_q;
    assign io_seg     = io_seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// tb_seg_mux_display: bench for seg_mux_display with DIGITS=4, DIV_BITS=2.
// A cycle-count based reference model predicts io_sel/io_seg/frame_done for
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_seg_mux_display;

    localparam int DIGITS   = 4;
    localparam int DIV_BITS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] values = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        update = 1'b0;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_done;

    seg_mux_display #(.DIGITS(DIGITS), .DIV_BITS(DIV_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .values     (values),
        .dp         (dp),
        .blank      (blank),
        .update     (update),
        .io_sel     (io_sel),
        .io_seg     (io_seg),
        .frame_done (frame_done)
    );

    // Clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // t counts cycles since reset; the dwell is 4 cycles and a frame is 16.
    int          t = 0;
    int          m_cnt, m_idx;
    logic        m_wrap;
    logic [15:0] m_val = '0, s_val = '0;
    logic [3:0]  m_dp = '0, m_blank = '0, s_dp = '0, s_blank = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fd;
    logic        check_en = 1'b0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                   7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                   7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [7:0] model_seg(logic [15:0] v, logic [3:0] d,
                                             logic [3:0] b, int i);
        logic [3:0] nib;
        logic [6:0] g;
        int         hi;
        nib = v[4*i +: 4];
        if (b[i]) return 8'hFF;
        g = glyph_tab[nib];
`ifdef SEG_LZ_SUPPRESS_EN
        hi = -1;
        for (int j = 0; j < 4; j++) if (v[4*j +: 4] != 4'h0) hi = j;
        if (i > 0 && i > hi) g = 7'h00;
`else
        hi = 0;
`endif
        return {~d[i], ~g};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_val = '0; m_dp = '0; m_blank = '0;
            s_val = '0; s_dp = '0; s_blank = '0;
            m_pend = 1'b0;
            e_sel = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
            check_en = 1'b1;
        end else begin
            m_cnt  = t % 4;
            m_idx  = (t / 4) % 4;
            m_wrap = (m_cnt == 3) && (m_idx == 3);
            e_sel  = (m_cnt == 0) ? 4'hF : ~(4'b0001 << m_idx);
            e_seg  = model_seg(m_val, m_dp, m_blank, m_idx);
            e_fd   = m_wrap;
            if (update && m_wrap) begin
                m_val = values; m_dp = dp; m_blank = blank; m_pend = 1'b0;
            end else if (m_wrap && m_pend) begin
                m_val = s_val; m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
            end else if (update) begin
                s_val = values; s_dp = dp; s_blank = blank; m_pend = 1'b1;
            end
            t++;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_io_sel", 32'(io_sel), 32'(e_sel));
            check("cyc_io_seg", 32'(io_seg), 32'(e_seg));
            check("cyc_frame_done", 32'(frame_done), 32'(e_fd));
            check("cyc_pending", 32'(dut.pending_q), 32'(m_pend));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input logic [15:0] v, input logic [3:0] d,
                          input logic [3:0] b);
        values = v; dp = d; blank = b; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic do_update(input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] b);
        @(negedge clk);
        strobe(v, d, b);
    endtask

    // Stop at the negedge whose following posedge is frame position ph.
    task automatic at_phase(input int ph);
        int n;
        n = 0;
        @(negedge clk);
        while ((t % 16) != ph && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((t % 16) != ph) timeout("at_phase");
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) timeout("wait_frame_done");
    endtask

    // Called at the negedge where frame_done is high; checks the next frame
    // literally: each digit gets a 1111 guard cycle then three select cycles.
    task automatic scan_frame(input string name, input logic [7:0] s3,
                              input logic [7:0] s2, input logic [7:0] s1,
                              input logic [7:0] s0);
        logic [7:0] segs [4];
        logic [3:0] sels [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        sels[0] = 4'b1110; sels[1] = 4'b1101; sels[2] = 4'b1011; sels[3] = 4'b0111;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check({name, "_sel"}, 32'(io_sel), (k % 4 == 0) ? 32'hF : 32'(sels[k/4]));
            check({name, "_seg"}, 32'(io_seg), 32'(segs[k/4]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_sel", 32'(io_sel), 32'hF);
        check("reset_seg", 32'(io_seg), 32'hFF);
        check("reset_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // Basic frame: 12AF, dp on digit 2.
        do_update(16'h12AF, 4'b0100, 4'b0000);
        wait_fd();
        scan_frame("first_frame", 8'hF9, 8'h24, 8'h88, 8'h8E);

        // Two updates within one frame: only the later one appears.
        at_phase(5);
        strobe(16'h0000, 4'b0000, 4'b0000);
        at_phase(10);
        strobe(16'h9999, 4'b0000, 4'b0000);
        wait_fd();
        scan_frame("overwrite", 8'h90, 8'h90, 8'h90, 8'h90);

        // Update exactly on the wrapping tick.
        at_phase(15);
        strobe(16'h5555, 4'b0000, 4'b0000);
        check("wrap_upd_fd", 32'(frame_done), 32'h1);
        check("wrap_upd_pending", 32'(dut.pending_q), 32'h0);
        scan_frame("wrap_update", 8'h92, 8'h92, 8'h92, 8'h92);

        // Blank digit 3 with its dp set.
        do_update(16'h0000, 4'b1000, 4'b1000);
        wait_fd();
`ifdef SEG_LZ_SUPPRESS_EN
        scan_frame("blank", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
        scan_frame("blank", 8'hFF, 8'hC0, 8'hC0, 8'hC0);
`endif

        // Leading zeros.
        do_update(16'h0070, 4'b1000, 4'b0000);
        wait_fd();
`ifdef SEG_LZ_SUPPRESS_EN
        scan_frame("lz", 8'h7F, 8'hFF, 8'hF8, 8'hC0);
`else
        scan_frame("lz", 8'h40, 8'hC0, 8'hF8, 8'hC0);
`endif

        // Reset mid-frame while idx=2 with an update pending.
        at_phase(8);
        strobe(16'h3333, 4'b0000, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sel", 32'(io_sel), 32'hF);
        check("midrst_seg", 32'(io_seg), 32'hFF);
        check("midrst_fd", 32'(frame_done), 32'h0);
        check("midrst_pending", 32'(dut.pending_q), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_guard", 32'(io_sel), 32'hF);
        @(negedge clk);
        check("restart_sel", 32'(io_sel), 32'hE);
        check("restart_seg", 32'(io_seg), 32'hC0);
        wait_fd();
        scan_frame("discard", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 199) == 0);
            update = ($urandom_range(0, 5) == 0);
            values = 16'($urandom);
            if ($urandom_range(0, 2) == 0) values = values >> (4 * $urandom_range(1, 4));
            dp     = 4'($urandom_range(0, 15));
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        update = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
